// File: rtl/cnt_sched.sv
`default_nettype none
// ============================================================================
// Module      : cnt_sched
// Description : Round-robin scheduler sharing one up-counter as a tick timer
//               between two requesters; pulses DONE at the owner's target.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_sched #(
    parameter int WIDTH = 8
) (
    input  logic             CCK,
    input  logic             NRST,
    input  logic             TICK,
    input  logic [1:0]       REQ,
    input  logic [WIDTH-1:0] TGT0,
    input  logic [WIDTH-1:0] TGT1,
    input  logic [1:0]       PERIODIC,
    output logic [1:0]       GNT,
    output logic [1:0]       DONE,
    output logic             BUSY,
    output logic             CNT_NCCLR,
    output logic             CNT_NCCKEN,
    input  logic [WIDTH-1:0] CNT_QDATA
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_owner;
    logic             r_last;
    logic             r_periodic;
    logic [WIDTH-1:0] r_tgt;

    logic w_winner;
    logic w_owner_req;
    logic w_terminal;

    // On a tie the requester that did not win last time takes the grant.
    assign w_winner    = (REQ == 2'b10) || ((REQ == 2'b11) && !r_last);
    assign w_owner_req = REQ[r_owner];
    assign w_terminal  = (r_state == S_RUN) && TICK && (CNT_QDATA == r_tgt);

    // Counter controls; reset forces a clear so the counter tracks the block.
    always_comb begin
        CNT_NCCLR  = 1'b1;
        CNT_NCCKEN = 1'b1;
        if (!NRST) begin
            CNT_NCCLR  = 1'b0;
            CNT_NCCKEN = 1'b0;
        end else begin
            case (r_state)
                S_CLR: begin
                    CNT_NCCLR  = 1'b0;
                    CNT_NCCKEN = 1'b0;
                end
                S_RUN: begin
                    CNT_NCCKEN = ~TICK;
                    CNT_NCCLR  = ~w_terminal;
                end
                default: begin
                    CNT_NCCLR  = 1'b1;
                    CNT_NCCKEN = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CCK) begin
        if (!NRST) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_periodic <= 1'b0;
            r_tgt      <= '0;
            GNT        <= 2'b00;
            DONE       <= 2'b00;
            BUSY       <= 1'b0;
        end else begin
            DONE <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (|REQ) begin
                        r_owner    <= w_winner;
                        r_last     <= w_winner;
                        r_tgt      <= w_winner ? TGT1 : TGT0;
                        r_periodic <= PERIODIC[w_winner];
                        GNT        <= w_winner ? 2'b10 : 2'b01;
                        BUSY       <= 1'b1;
                        r_state    <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (!w_owner_req) begin
                        GNT     <= 2'b00;
                        BUSY    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A dropped request wins over a terminal in the same cycle.
                    if (!w_owner_req) begin
                        GNT     <= 2'b00;
                        BUSY    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_terminal) begin
                        DONE <= r_owner ? 2'b10 : 2'b01;
                        if (!r_periodic) begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    if (!w_owner_req) begin
                        GNT     <= 2'b00;
                        BUSY    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnt_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt_sched
// Description : Self-checking bench for cnt_sched with a behavioural counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_sched;

    logic       CCK = 1'b0;
    logic       NRST;
    logic       TICK;
    logic [1:0] REQ;
    logic [7:0] TGT0, TGT1;
    logic [1:0] PERIODIC;
    logic [1:0] GNT, DONE;
    logic       BUSY, CNT_NCCLR, CNT_NCCKEN;
    logic [7:0] q;

    int checks = 0;
    int passes = 0;

    always #5 CCK = ~CCK;

    // Shared up-counter: clear takes effect when enabled, else count.
    always_ff @(posedge CCK) begin
        if (!CNT_NCCKEN && !CNT_NCCLR) q <= 8'd0;
        else if (!CNT_NCCKEN)          q <= q + 8'd1;
    end

    cnt_sched #(.WIDTH(8)) dut (
        .CCK(CCK), .NRST(NRST), .TICK(TICK), .REQ(REQ),
        .TGT0(TGT0), .TGT1(TGT1), .PERIODIC(PERIODIC),
        .GNT(GNT), .DONE(DONE), .BUSY(BUSY),
        .CNT_NCCLR(CNT_NCCLR), .CNT_NCCKEN(CNT_NCCKEN), .CNT_QDATA(q)
    );

    typedef struct {
        logic [1:0] req;
        logic [7:0] t0;
        logic [7:0] t1;
        logic [1:0] gnt;
        int         cyc;   // edges from grant until DONE is visible (tgt+2)
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(negedge CCK);
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (DONE == 2'b00 && n < limit);
    endtask

    task automatic do_reset();
        NRST = 1'b0;
        cyc();
        cyc();
        NRST = 1'b1;
    endtask

    int n, t_prev, t_now, pulses;
    logic [7:0] q_frozen;
    logic       extra_done;

    initial begin
        NRST = 1'b0; TICK = 1'b0; REQ = 2'b11; TGT0 = 8'd0; TGT1 = 8'd0; PERIODIC = 2'b00;

        // Reset with both requests pending
        cyc(); cyc();
        chk("rst_gnt", GNT, 2'b00);
        chk("rst_done", DONE, 2'b00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_nclr", CNT_NCCLR, 1'b0);
        chk("rst_ncken", CNT_NCCKEN, 1'b0);
        NRST = 1'b1;
        cyc();
        chk("rst_first_gnt", GNT, 2'b01);
        REQ = 2'b00;
        cyc();
        chk("rst_abort_gnt", GNT, 2'b00);
        do_reset();

        // One-shot transactions; ties alternate against the previous winner
        tbl[0] = '{2'b01, 8'd3, 8'd0, 2'b01, 5};
        tbl[1] = '{2'b11, 8'd1, 8'd2, 2'b10, 4};
        tbl[2] = '{2'b11, 8'd1, 8'd9, 2'b01, 3};
        tbl[3] = '{2'b10, 8'd4, 8'd0, 2'b10, 2};
        tbl[4] = '{2'b11, 8'd0, 8'd6, 2'b01, 2};
        tbl[5] = '{2'b01, 8'd9, 8'd1, 2'b01, 11};
        tbl[6] = '{2'b11, 8'd2, 8'd5, 2'b10, 7};
        TICK = 1'b1;
        for (int i = 0; i < 7; i++) begin
            REQ = tbl[i].req; TGT0 = tbl[i].t0; TGT1 = tbl[i].t1; PERIODIC = 2'b00;
            cyc();
            chk($sformatf("v%0d_gnt", i), GNT, tbl[i].gnt);
            chk($sformatf("v%0d_busy", i), BUSY, 1'b1);
            TGT0 = 8'd200; TGT1 = 8'd200;
            wait_done(40, n);
            chk($sformatf("v%0d_latency", i), n, tbl[i].cyc);
            chk($sformatf("v%0d_done", i), DONE, tbl[i].gnt);
            chk($sformatf("v%0d_wrap", i), q, 8'd0);
            cyc();
            chk($sformatf("v%0d_done_w", i), DONE, 2'b00);
            chk($sformatf("v%0d_fin_hold", i), GNT, tbl[i].gnt);
            REQ = 2'b00;
            cyc();
            chk($sformatf("v%0d_release", i), GNT, 2'b00);
            chk($sformatf("v%0d_idle", i), BUSY, 1'b0);
        end

        // Round-robin with the loser kept waiting (last winner was requester 1)
        REQ = 2'b11; TGT0 = 8'd1; TGT1 = 8'd1;
        cyc();
        chk("rr_first", GNT, 2'b01);
        wait_done(20, n);
        chk("rr_first_done", DONE, 2'b01);
        cyc(); cyc();
        chk("rr_hold0", GNT, 2'b01);
        REQ = 2'b10;
        cyc();
        chk("rr_rel0", GNT, 2'b00);
        cyc();
        chk("rr_second", GNT, 2'b10);
        wait_done(20, n);
        chk("rr_second_done", DONE, 2'b10);
        REQ = 2'b00;
        cyc();
        chk("rr_rel1", GNT, 2'b00);
        REQ = 2'b11;
        cyc();
        chk("rr_third", GNT, 2'b01);
        REQ = 2'b00;
        cyc();

        // Periodic: tick every 3rd cycle, tgt 2 -> DONE every 9 cycles
        REQ = 2'b10; TGT1 = 8'd2; PERIODIC = 2'b10; TICK = 1'b0;
        pulses = 0; t_prev = 0;
        for (int c = 1; c < 200 && pulses < 4; c++) begin
            TICK = (c % 3 == 0);
            cyc();
            if (DONE != 2'b00) begin
                pulses++;
                chk("per_owner", DONE, 2'b10);
                if (pulses > 1) chk("per_spacing", c - t_prev, 9);
                t_prev = c;
            end
        end
        chk("per_pulses", pulses, 4);
        REQ = 2'b00; TICK = 1'b0;
        cyc();
        chk("per_abort_gnt", GNT, 2'b00);
        q_frozen = q;
        extra_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            TICK = (c % 3 == 0);
            cyc();
            if (DONE != 2'b00) extra_done = 1'b1;
        end
        chk("per_no_5th", extra_done, 1'b0);
        chk("per_q_frozen", q, q_frozen);
        PERIODIC = 2'b00;

        // Abort mid-count at q=5
        REQ = 2'b01; TGT0 = 8'd10; TICK = 1'b1;
        cyc(); cyc();
        n = 0;
        while (q != 8'd5 && n < 30) begin cyc(); n++; end
        chk("ab_reach5", q, 8'd5);
        REQ = 2'b00;
        cyc();
        chk("ab_gnt", GNT, 2'b00);
        chk("ab_done", DONE, 2'b00);
        chk("ab_ncken", CNT_NCCKEN, 1'b1);

        // Abort coinciding with the terminal tick
        REQ = 2'b01; TGT0 = 8'd3;
        cyc(); cyc();
        n = 0;
        while (q != 8'd3 && n < 30) begin cyc(); n++; end
        chk("abt_reach3", q, 8'd3);
        REQ = 2'b00;
        cyc();
        chk("abt_done", DONE, 2'b00);
        chk("abt_gnt", GNT, 2'b00);
        cyc();
        chk("abt_done2", DONE, 2'b00);

        // Full-range periodic target
        REQ = 2'b10; TGT1 = 8'd255; PERIODIC = 2'b10; TICK = 1'b1;
        cyc();
        wait_done(600, n);
        chk("full_first", n, 257);
        chk("full_wrap1", q, 8'd0);
        wait_done(600, n);
        chk("full_period", n, 256);
        chk("full_wrap2", q, 8'd0);
        chk("full_done", DONE, 2'b10);
        REQ = 2'b00;
        cyc();
        chk("full_release", GNT, 2'b00);

        // Reset in the middle of a run aborts silently
        REQ = 2'b01; TGT0 = 8'd2; PERIODIC = 2'b00;
        cyc(); cyc(); cyc();
        NRST = 1'b0;
        cyc();
        chk("mid_rst_gnt", GNT, 2'b00);
        chk("mid_rst_done", DONE, 2'b00);
        REQ = 2'b00;
        NRST = 1'b1;
        cyc();
        chk("mid_rst_busy", BUSY, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cnt_sched.md
Name: cnt_sched

Overview:
- Shares one loadable up-counter (8-bit, active-low clear/enable controls, QDATA feedback) between two requesters as a programmable tick timer.
- Arbitrates round-robin, clears the counter on grant and counts divided-clock ticks.
- Compares the count against the winner's latched target and pulses DONE at terminal count.
- Sits between the clock divider's tick output and the counter instance; the parent ties the counter's NCLOAD high and DATA to 0.

Parameters:
WIDTH, 8, counter/target width; QDATA compare and target latch are WIDTH bits.

Ports:
CCK  in  1  system clock; all logic on posedge.
NRST  in  1  reset, synchronous, active-low.
TICK  in  1  single-cycle count-enable pulse from the clock divider (already in the CCK domain).
REQ  in  2  per-requester request level; 4-phase handshake.
TGT0  in  WIDTH  requester 0 terminal count; sampled at grant.
TGT1  in  WIDTH  requester 1 terminal count; sampled at grant.
PERIODIC  in  2  per-requester mode (1 = auto-repeat); sampled at grant.
GNT  out  2  one-hot grant, registered.
DONE  out  2  terminal-count pulse to the owner, registered, 1 cycle wide.
BUSY  out  1  high in any state except IDLE, registered.
CNT_NCCLR  out  1  counter clear, active-low, combinational.
CNT_NCCKEN  out  1  counter enable, active-low, combinational.
CNT_QDATA  in  WIDTH  counter value feedback.

Behaviour:
- Reset (NRST low at posedge):
  - state=IDLE, GNT=00, DONE=00, BUSY=0, owner=0, LAST=1 (requester 0 wins the first tie).
  - While NRST is low, CNT_NCCLR=0 and CNT_NCCKEN=0 combinationally, so the counter clears alongside the block.
  - Reset mid-operation aborts silently: no DONE.
- States: IDLE, CLR, RUN, FIN (2-bit encoding).
- IDLE:
  - CNT_NCCKEN=1, CNT_NCCLR=1.
  - If any REQ bit is high: pick the winner (single request -> that one; both -> ~LAST).
  - Latch TGT and PERIODIC of the winner; set GNT and LAST=winner; go to CLR.
  - Grant latency: 1 cycle after REQ is sampled high.
- CLR: one cycle with CNT_NCCKEN=0, CNT_NCCLR=0; the counter reads 0 at the next edge; go to RUN.
- RUN:
  - CNT_NCCKEN = ~TICK.
  - Terminal condition = TICK & (CNT_QDATA == tgt).
  - On terminal, CNT_NCCLR=0 in that same cycle (the counter wraps to 0), and DONE[owner] is set for the next cycle.
  - Period = tgt+1 ticks. tgt=0 gives DONE on every tick. tgt=2^WIDTH-1 counts the full range with no overflow path.
  - On terminal with PERIODIC[owner]=1 and REQ[owner]=1: stay in RUN.
  - On terminal with PERIODIC[owner]=0: go to FIN.
- FIN: CNT_NCCKEN=1; hold GNT until REQ[owner]=0, then go to IDLE with GNT=00 at that edge.
- Abort:
  - REQ[owner]=0 in CLR or RUN -> IDLE at the next edge, GNT=00, no DONE.
  - Abort beats a simultaneous terminal.
- The non-owner's REQ is ignored until IDLE; the earliest regrant is 1 cycle after returning to IDLE.
- TGT/PERIODIC changes after grant have no effect.
- TICK outside RUN is ignored.
- CNT_QDATA is trusted; a value above tgt is not corrected (it wraps naturally).

Test Plan:
1. Reset: hold NRST=0 for 2 cycles with REQ=11 -> GNT=00, DONE=00, BUSY=0, CNT_NCCLR=0, CNT_NCCKEN=0; after release GNT=01 one cycle later.
2. One-shot: REQ=01, TGT0=3, TICK every cycle -> GNT=01 at +1, CLR at +1..+2, QDATA 0,1,2,3, DONE=01 exactly 1 cycle after the QDATA=3 tick; FIN holds GNT until REQ0 drops, then GNT=00 next edge.
3. Periodic: REQ=10, TGT1=2, PERIODIC=10, TICK every 3rd cycle -> DONE[1] every 9 cycles, 4 pulses; drop REQ1 -> IDLE next edge, no 5th pulse, QDATA frozen.
4. Round-robin: REQ=11 from reset, both one-shot, TGT=1 -> order 01 then 10 then 01; each GNT released only after its REQ drop.
5. Abort: REQ0 with TGT0=10, drop REQ0 when QDATA=5 -> GNT=00 next edge, no DONE, CNT_NCCKEN=1; also drop REQ0 on the terminal-tick cycle -> no DONE.
6. Boundaries: TGT0=0 one-shot -> DONE on the first RUN tick; TGT1=255 periodic -> DONE every 256 ticks, QDATA wraps 255->0 via CNT_NCCLR.
